// File: rtl/fsm_seq_ctrl.sv
// Round-robin front end that serialises requester words into a shared
// Mealy FSM and returns its per-bit y/z outputs as response words.
module fsm_seq_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_y,
    output logic [W-1:0] rsp_z,
    output logic         busy,
    output logic         fsm_clr,
    output logic         fsm_x,
    input  logic         fsm_y,
    input  logic         fsm_z
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        RESP
    } state_t;

    state_t         state;
    logic [W-1:0]   sreg;
    logic [CW-1:0]  cnt;
    logic           last_grant;
    logic           idle_ok;
    logic           pick1;

    // readys are masked while reset is held so nothing looks accepted
    assign idle_ok    = rst & (state == IDLE);
    assign pick1      = req1_valid & (~req0_valid | ~last_grant);
    assign req0_ready = idle_ok & req0_valid & ~pick1;
    assign req1_ready = idle_ok & pick1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_z      <= '0;
            busy       <= 1'b0;
            fsm_clr    <= 1'b0;
            fsm_x      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        sreg       <= pick1 ? req1_data : req0_data;
                        rsp_id     <= pick1;
                        last_grant <= pick1;
                        busy       <= 1'b1;
                        fsm_clr    <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    fsm_clr <= 1'b0;
                    cnt     <= '0;
                    fsm_x   <= sreg[0];
                    state   <= SHIFT;
                end
                SHIFT: begin
                    rsp_y[cnt] <= fsm_y;
                    rsp_z[cnt] <= fsm_z;
                    sreg       <= sreg >> 1;
                    cnt        <= cnt + 1'b1;
                    // fsm_x always presents the bit now at sreg[0]
                    if (cnt == CW'(W - 1)) begin
                        fsm_x     <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        fsm_x <= sreg[1];
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl with a small behavioural Mealy FSM
// standing in for the shared datapath.
module tb_fsm_seq_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_y;
    logic [W-1:0] rsp_z;
    logic         busy;
    logic         fsm_clr;
    logic         fsm_x;
    logic         fsm_y;
    logic         fsm_z;

    int total = 0;
    int bad   = 0;
    int n;
    int clrs;
    logic         mode;
    logic         prev;
    logic         got;
    logic [W-1:0] d;
    logic [W-1:0] ry;
    logic [W-1:0] rz;
    logic [2*W-1:0] ex;
    logic [W-1:0] vals [4];

    fsm_seq_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_z      (rsp_z),
        .busy       (busy),
        .fsm_clr    (fsm_clr),
        .fsm_x      (fsm_x),
        .fsm_y      (fsm_y),
        .fsm_z      (fsm_z)
    );

    // mode 0: y=x, z=~x; mode 1: y=x^prev, z=x&prev, prev cleared by fsm_clr
    always @(posedge clk or negedge rst) begin
        if (!rst)         prev <= 1'b0;
        else if (fsm_clr) prev <= 1'b0;
        else              prev <= fsm_x;
    end

    assign fsm_y = mode ? (fsm_x ^ prev) : fsm_x;
    assign fsm_z = mode ? (fsm_x & prev) : ~fsm_x;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got_v,
                         input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] dat,
                                             input logic m);
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic p;
        logic x;
        p = 1'b0;
        y = '0;
        z = '0;
        for (int k = 0; k < W; k++) begin
            x    = dat[k];
            y[k] = m ? (x ^ p) : x;
            z[k] = m ? (x & p) : ~x;
            p    = x;
        end
        return {z, y};
    endfunction

    task automatic do_reset;
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b0;
        mode       = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h3C;
        req1_data  = 8'hC3;
        rsp_ready  = 1'b1;
        vals[0]    = 8'h6B;
        vals[1]    = 8'hFF;
        vals[2]    = 8'h01;
        vals[3]    = 8'h96;
        tick;
        tick;
        tick;
        check("rst_vld",  32'(rsp_valid), 0);
        check("rst_id",   32'(rsp_id), 0);
        check("rst_y",    32'(rsp_y), 0);
        check("rst_z",    32'(rsp_z), 0);
        check("rst_clr",  32'(fsm_clr), 0);
        check("rst_x",    32'(fsm_x), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdy0", 32'(req0_ready), 0);
        check("rst_rdy1", 32'(req1_ready), 0);
        req1_valid = 1'b0;
        rst        = 1'b1;
        #1;
        check("rel_rdy0", 32'(req0_ready), 1);

        // single transfer, accept edge is the end of cycle 0
        req0_data = 8'hA5;
        d         = 8'hA5;
        #1;
        tick;
        req0_valid = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            check("sgl_clr",  32'(fsm_clr), 32'(c == 1));
            check("sgl_busy", 32'(busy), 1);
            check("sgl_vld",  32'(rsp_valid), 32'(c == W + 2));
            if (c >= 2 && c <= W + 1)
                check("sgl_x", 32'(fsm_x), 32'(d[c-2]));
            if (c < W + 2) tick;
        end
        check("sgl_id", 32'(rsp_id), 0);
        check("sgl_y",  32'(rsp_y), 32'h A5);
        check("sgl_z",  32'(rsp_z), 32'h 5A);
        tick;
        check("sgl_idle", 32'(busy), 0);
        check("sgl_drop", 32'(rsp_valid), 0);

        // arbitration with both requesters continuously valid
        do_reset;
        req0_data  = 8'h0F;
        req1_data  = 8'hF0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!(req0_ready | req1_ready) && n < 40) begin
                tick;
                n++;
            end
            check("arb_seen",  32'(req0_ready | req1_ready), 1);
            check("arb_both",  32'(req0_ready & req1_ready), 0);
            check("arb_grant", 32'(req1_ready), t % 2);
            tick;
            n = 0;
            while (!rsp_valid && n < 40) begin
                check("arb_both", 32'(req0_ready & req1_ready), 0);
                tick;
                n++;
            end
            check("arb_rsp",  32'(rsp_valid), 1);
            check("arb_id",   32'(rsp_id), t % 2);
            check("arb_y",    32'(rsp_y), (t % 2) ? 32'h F0 : 32'h 0F);
            tick;
        end

        // backpressure
        do_reset;
        req0_data  = 8'h3C;
        req0_valid = 1'b1;
        rsp_ready  = 1'b0;
        #1;
        tick;
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
        check("bp_seen", 32'(rsp_valid), 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_vld",  32'(rsp_valid), 1);
            check("bp_id",   32'(rsp_id), 0);
            check("bp_y",    32'(rsp_y), 32'h 3C);
            check("bp_z",    32'(rsp_z), 32'h C3);
            check("bp_rdy0", 32'(req0_ready), 0);
            check("bp_rdy1", 32'(req1_ready), 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick;
        check("bp_idle", 32'(busy), 0);
        check("bp_drop", 32'(rsp_valid), 0);

        // reset during the shift of a requester 1 word
        req1_data  = 8'h5A;
        req1_valid = 1'b1;
        #1;
        check("mid_rdy1", 32'(req1_ready), 1);
        tick;
        req1_valid = 1'b0;
        tick;
        tick;
        tick;
        tick;
        check("mid_x3",   32'(fsm_x), 1);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rx",   32'(fsm_x), 0);
        check("mid_rb",   32'(busy), 0);
        check("mid_rclr", 32'(fsm_clr), 0);
        check("mid_rvld", 32'(rsp_valid), 0);
        tick;
        tick;
        req0_data  = 8'h81;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst        = 1'b1;
        #1;
        check("mid_g0", 32'(req0_ready), 1);
        check("mid_g1", 32'(req1_ready), 0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
        check("mid_rsp", 32'(rsp_valid), 1);
        check("mid_id",  32'(rsp_id), 0);
        check("mid_y",   32'(rsp_y), 32'h 81);
        tick;

        // back-to-back with a stateful FSM model
        do_reset;
        mode       = 1'b1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        #1;
        for (int t = 0; t < 4; t++) begin
            check("b2b_rdy", 32'(req0_ready), 1);
            req0_data = vals[t];
            ex        = model(vals[t], 1'b1);
            tick;
            n    = 1;
            clrs = 0;
            got  = 1'b0;
            ry   = '0;
            rz   = '0;
            while (!req0_ready && n < 30) begin
                clrs += int'(fsm_clr);
                if (rsp_valid) begin
                    ry  = rsp_y;
                    rz  = rsp_z;
                    got = 1'b1;
                end
                tick;
                n++;
            end
            check("b2b_gap", 32'(n), W + 3);
            check("b2b_clr", 32'(clrs), 1);
            check("b2b_got", 32'(got), 1);
            check("b2b_y",   32'(ry), 32'(ex[W-1:0]));
            check("b2b_z",   32'(rz), 32'(ex[2*W-1:W]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
- Controller that shares one serial Mealy-FSM datapath (1-bit input x, 1-bit outputs y and z) between two requesters.
- Each requester hands over a W-bit word. The controller arbitrates round-robin, clears the FSM, and shifts the word into it LSB-first, one bit per cycle.
- It captures the FSM's y/z outputs for each bit and returns them as two W-bit words with a valid/ready handshake.
- It sits between the requesting logic and the FSM instance; the FSM itself is external.

Parameters:
- W, 8, word width and number of shift cycles per transfer; legal range W >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  W  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid&ready.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  W  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid&ready.
- rsp_valid  output  1  response words valid.
- rsp_ready  input  1  consumer takes the response when valid&ready.
- rsp_id  output  1  index of the requester that owns the response.
- rsp_y  output  W  captured y bits; bit k corresponds to input bit k.
- rsp_z  output  W  captured z bits; bit k corresponds to input bit k.
- busy  output  1  high in every state except IDLE.
- fsm_clr  output  1  one-cycle clear pulse to the FSM (returns it to its reset state).
- fsm_x  output  1  serial bit into the FSM; registered, glitch-free.
- fsm_y  input  1  FSM Mealy output y; combinational from fsm_x and FSM state.
- fsm_z  input  1  FSM Mealy output z; combinational from fsm_x and FSM state.

Behaviour:
- States: IDLE, CLEAR, SHIFT, RESP. Registered state; one always_ff with async reset on negedge rst.
- Reset (rst=0): state=IDLE; rsp_valid, rsp_id, rsp_y, rsp_z, fsm_clr, fsm_x, busy all 0; bit counter 0; last_grant=1, so requester 0 wins first.
- Reset mid-operation: the transfer in flight is discarded and no response is issued. After release, operation resumes from IDLE with requester 0 priority.
- IDLE:
  - Winner = the only valid requester. If both are valid, the one that is not last_grant wins.
  - reqN_ready = (state==IDLE) & winner==N. It is combinational and never high for both requesters.
  - On valid&ready: latch data into the shift register, set owner id, set last_grant=id, go to CLEAR.
  - With no valid request: stay in IDLE; both readys are 0.
- CLEAR: one cycle; fsm_clr=1, fsm_x=0; counter cleared; go to SHIFT.
- SHIFT: exactly W cycles, counter k=0..W-1.
  - fsm_x = shift_reg[0], driven from a register.
  - At each rising edge: rsp_y[k]<=fsm_y, rsp_z[k]<=fsm_z, shift_reg shifts right, k increments.
  - At k==W-1 go to RESP. fsm_clr=0 throughout.
- RESP:
  - rsp_valid=1; rsp_id, rsp_y, rsp_z stay stable until rsp_valid&rsp_ready.
  - On the handshake edge: rsp_valid drops and state returns to IDLE. fsm_x=0.
- Latency: accept edge at cycle 0 → fsm_clr high in cycle 1 → bits in cycles 2..W+1 → rsp_valid high from cycle W+2.
- Minimum period per transfer: W+3 cycles, since acceptance happens only in IDLE.
- Backpressure: while rsp_ready=0, both req readys stay 0 and no new word is accepted.
- Simultaneous valid on both requesters: exactly one is granted, and grants alternate while both stay valid.
- A requester may drop valid before it is granted; it is not granted in that case.
- rsp_y/rsp_z keep their last values outside RESP; they are meaningful only while rsp_valid=1.

Test Plan:
- Reset: hold rst=0 with arbitrary inputs → all outputs 0, busy=0. Release with req0_valid=1 → req0_ready=1 that cycle.
- Single transfer: req0 data=8'hA5; bench model drives fsm_y=fsm_x, fsm_z=~fsm_x.
  - fsm_clr=1 only in cycle 1.
  - fsm_x over cycles 2..9 = 1,0,1,0,0,1,0,1.
  - rsp_valid in cycle 10 with rsp_id=0, rsp_y=8'hA5, rsp_z=8'h5A.
- Arbitration: both valid continuously from reset, data0=8'h0F, data1=8'hF0 → grants go req0, req1, req0, req1, and rsp_id alternates 0,1,0,1.
  - Each rsp_y equals its own data.
  - req0_ready and req1_ready are never both 1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_valid, rsp_id, rsp_y, rsp_z stable and both readys 0. On rsp_ready=1 the handshake completes and the state returns to IDLE the next cycle.
- Reset mid-SHIFT: pull rst=0 at bit 3 of a req1 transfer → outputs 0 immediately; no response for the aborted word. With both valid after release, req0 is granted first.
- Back-to-back: rsp_ready tied 1, req0_valid tied 1 → a new accept every W+3 = 11 cycles. Each response is correct against the bench FSM model, with fsm_clr asserted once per transfer.
